// File: rtl/milano_pkg.sv
// Shared types for the milano IF stage: word sizes, fetch FSM states and the
// {pc, instr} entry carried from the instruction bus toward ID.
package milano_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } if_entry_t;

  // Instruction fetches are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/milano_fetch_fifo.sv
// Small circular FIFO of fetched {pc, instr} entries with synchronous flush.
// Head is read straight from the storage registers; it reads as zero when empty.
module milano_fetch_fifo
  import milano_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  if_entry_t     wr_entry,
  input  logic          pop,
  input  logic          flush,
  output if_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  if_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count do. Stale
  // contents are never observable because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/milano_if_ctrl.sv
// milano IF-stage fetch controller: owns the PC, runs req/gnt/rvalid word
// fetches, buffers results toward ID and handles EX redirects.
// Optional build macro MILANO_IF_PERF_EN adds fetch and stall counters.
module milano_if_ctrl
  import milano_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [XLEN-1:0]       boot_addr_i,
  input  logic                  fetch_en_i,
  output logic                  instr_req_o,
  output logic [XLEN-1:0]       instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [ILEN-1:0]       instr_rdata_i,
  input  logic                  redirect_i,
  input  logic [XLEN-1:0]       redirect_pc_i,
  output logic                  instr_valid_o,
  output logic [ILEN-1:0]       instr_o,
  output logic [XLEN-1:0]       instr_pc_o,
  input  logic                  id_ready_i,
  output logic                  busy_o,
  output logic [PERF_CNT_W-1:0] perf_fetch_cnt_o,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            pc_loaded_q, pc_loaded_d;
  logic            discard_q, discard_d;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_next;
  logic            space_next;
  if_entry_t       push_entry;
  if_entry_t       head;

  // A response arriving in the redirect cycle belongs to the old path.
  assign fifo_push  = (state_q == IF_WAIT) & instr_rvalid_i & ~discard_q & ~redirect_i;
  assign fifo_pop   = ~fifo_empty & id_ready_i;
  assign push_entry = '{pc: req_pc_q, instr: instr_rdata_i};

  milano_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (fifo_push),
    .wr_entry (push_entry),
    .pop      (fifo_pop),
    .flush    (redirect_i),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Occupancy after this edge; a new request may only issue if its response
  // is guaranteed a slot.
  always_comb begin
    count_next = fifo_count;
    if (redirect_i) begin
      count_next = '0;
    end else if (fifo_push && !fifo_pop && !fifo_full) begin
      count_next = fifo_count + CW'(1);
    end else if (!fifo_push && fifo_pop) begin
      count_next = fifo_count - CW'(1);
    end
  end

  assign space_next = (count_next < CW'(FIFO_DEPTH));

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    pc_loaded_d = pc_loaded_q;
    discard_d   = discard_q;

    case (state_q)
      IF_IDLE: begin
        if (fetch_en_i && space_next) begin
          state_d = IF_REQ;
          if (!pc_loaded_q) begin
            pc_d        = word_align(boot_addr_i);
            pc_loaded_d = 1'b1;
          end
        end
      end
      IF_REQ: begin
        if (instr_gnt_i) begin
          state_d  = IF_WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
        end
      end
      IF_WAIT: begin
        if (instr_rvalid_i) begin
          discard_d = 1'b0;
          state_d   = (fetch_en_i && space_next) ? IF_REQ : IF_IDLE;
        end
      end
      default: state_d = IF_IDLE;
    endcase

    // Redirect overrides the PC; a transaction still in flight on the old
    // path must have its response thrown away.
    if (redirect_i) begin
      pc_d        = word_align(redirect_pc_i);
      pc_loaded_d = 1'b1;
      if ((state_q == IF_WAIT && !instr_rvalid_i) ||
          (state_q == IF_REQ  && instr_gnt_i)) begin
        discard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IF_IDLE;
      pc_q        <= '0;
      req_pc_q    <= '0;
      pc_loaded_q <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      pc_loaded_q <= pc_loaded_d;
      discard_q   <= discard_d;
    end
  end

  assign instr_req_o   = (state_q == IF_REQ);
  assign instr_addr_o  = pc_q;
  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
  assign busy_o        = (state_q != IF_IDLE) | discard_q;

`ifdef MILANO_IF_PERF_EN
  logic [PERF_CNT_W-1:0] fetch_cnt_q;
  logic [PERF_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fifo_push)                  fetch_cnt_q <= fetch_cnt_q + PERF_CNT_W'(1);
      if (instr_req_o && !instr_gnt_i) stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_fetch_cnt_o = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule
